// File: rtl/intr_pkg.sv
// Shared types and defaults for the interrupt controller / return-stack arbiter.
package intr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PUSH    = 3'd1,
        ST_JUMP    = 3'd2,
        ST_SERVICE = 3'd3,
        ST_RETURN  = 3'd4
    } state_t;

    localparam int NUM_IRQ         = 2;
    localparam int DEF_PC_WIDTH    = 10;
    localparam int DEF_STACK_DEPTH = 8;

    // Fixed priority: irq1 (bit 0) beats irq2 (bit 1); result is one-hot or zero.
    function automatic logic [NUM_IRQ-1:0] pick_fixed(input logic [NUM_IRQ-1:0] req);
        logic [NUM_IRQ-1:0] g;
        g = '0;
        if (req[0])
            g[0] = 1'b1;
        else if (req[1])
            g[1] = 1'b1;
        return g;
    endfunction

endpackage

// File: rtl/intr_edge_det.sv
// Rising-edge detector for one interrupt line with a pending latch.
// An edge only sets pending when set_en is high; clr wins over a simultaneous edge.
module intr_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    input  logic set_en,
    input  logic clr,
    output logic pending
);

    logic irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q   <= 1'b0;
            pending <= 1'b0;
        end else begin
            irq_q <= irq;
            if (clr)
                pending <= 1'b0;
            else if (irq && !irq_q && set_en)
                pending <= 1'b1;
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller and return-stack arbiter for the single-cycle CPU.
// Optional build macro: INTR_ROUND_ROBIN_EN (alternating grant on ties; default fixed priority).
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int PC_WIDTH    = DEF_PC_WIDTH,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                irq1,
    input  logic                irq2,
    input  logic                ien,
    input  logic                reti,
    input  logic                cpu_push,
    input  logic                cpu_pop,
    input  logic [PC_WIDTH-1:0] cpu_push_data,
    input  logic [PC_WIDTH-1:0] pc_next,
    input  logic [PC_WIDTH-1:0] vec1,
    input  logic [PC_WIDTH-1:0] vec2,
    output logic                stk_push,
    output logic                stk_pop,
    output logic [PC_WIDTH-1:0] stk_din,
    output logic                pc_load,
    output logic [PC_WIDTH-1:0] pc_vec,
    output logic [1:0]          in_service,
    output logic                busy,
    output logic                overflow,
    output logic                underflow
);

    localparam int                 DEPTH_W   = $clog2(STACK_DEPTH) + 1;
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

    state_t               state;
    state_t               state_nxt;
    logic [NUM_IRQ-1:0]   pending;
    logic [NUM_IRQ-1:0]   grant;
    logic [NUM_IRQ-1:0]   grant_nxt;
    logic [NUM_IRQ-1:0]   arb;
    logic [NUM_IRQ-1:0]   irq_vec;
    logic [NUM_IRQ-1:0]   set_vec;
    logic [NUM_IRQ-1:0]   clr_vec;
    logic [DEPTH_W-1:0]   depth;
    logic [DEPTH_W-1:0]   depth_nxt;
    logic                 full;
    logic                 empty;
    logic                 pass;
    logic                 ovf_set;
    logic                 udf_set;
    logic                 take_irq;

    assign irq_vec = {irq2, irq1};
    assign set_vec = ~in_service;
    assign clr_vec = (state == ST_JUMP) ? grant : '0;
    assign full    = (depth == DEPTH_MAX);
    assign empty   = (depth == '0);

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_irq
        intr_edge_det u_det (
            .clk     (clk),
            .reset   (reset),
            .irq     (irq_vec[i]),
            .set_en  (set_vec[i]),
            .clr     (clr_vec[i]),
            .pending (pending[i])
        );
    end

    // Entry only starts from an idle stack port with room for the return address.
    assign take_irq = (state == ST_IDLE) && ien && (pending != '0) &&
                      !cpu_push && !cpu_pop && !full;

`ifdef INTR_ROUND_ROBIN_EN
    logic last_irq2;

    always_ff @(posedge clk) begin
        if (reset)
            last_irq2 <= 1'b1;
        else if (take_irq)
            last_irq2 <= arb[1];
    end

    always_comb begin
        arb = pick_fixed(pending);
        if (pending == 2'b11)
            arb = last_irq2 ? 2'b01 : 2'b10;
    end
`else
    always_comb begin
        arb = pick_fixed(pending);
    end
`endif

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_din   = '0;
        pc_load   = 1'b0;
        pc_vec    = '0;
        busy      = 1'b0;
        pass      = 1'b0;
        ovf_set   = 1'b0;
        udf_set   = 1'b0;

        case (state)
            ST_IDLE: begin
                pass = 1'b1;
                if (take_irq) begin
                    state_nxt = ST_PUSH;
                    grant_nxt = arb;
                end
            end
            ST_PUSH: begin
                stk_push  = 1'b1;
                stk_din   = pc_next;
                busy      = 1'b1;
                state_nxt = ST_JUMP;
            end
            ST_JUMP: begin
                pc_load   = 1'b1;
                pc_vec    = grant[1] ? vec2 : vec1;
                busy      = 1'b1;
                state_nxt = ST_SERVICE;
            end
            ST_SERVICE: begin
                pass = 1'b1;
                if (reti)
                    state_nxt = ST_RETURN;
            end
            ST_RETURN: begin
                stk_pop   = 1'b1;
                busy      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Program call/return traffic; a simultaneous push and pop cancels out.
        if (pass && (cpu_push != cpu_pop)) begin
            if (cpu_push) begin
                if (full) begin
                    ovf_set = 1'b1;
                end else begin
                    stk_push = 1'b1;
                    stk_din  = cpu_push_data;
                end
            end else begin
                if (empty)
                    udf_set = 1'b1;
                else
                    stk_pop = 1'b1;
            end
        end

        // No strobe may escape while reset is held, whatever state we were in.
        if (reset) begin
            stk_push = 1'b0;
            stk_pop  = 1'b0;
            stk_din  = '0;
            pc_load  = 1'b0;
            pc_vec   = '0;
            busy     = 1'b0;
        end
    end

    always_comb begin
        depth_nxt = depth;
        case ({stk_push, stk_pop})
            2'b10:   depth_nxt = depth + DEPTH_W'(1);
            2'b01:   depth_nxt = depth - DEPTH_W'(1);
            default: depth_nxt = depth;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            grant      <= '0;
            in_service <= '0;
            depth      <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            depth <= depth_nxt;
            if (state == ST_JUMP)
                in_service <= grant;
            else if (state == ST_RETURN)
                in_service <= '0;
            if (ovf_set)
                overflow <= 1'b1;
            if (udf_set)
                underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed self-checking bench for intr_ctrl (default fixed-priority build).
module tb_intr_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       irq1, irq2, ien, reti, cpu_push, cpu_pop;
    logic [9:0] cpu_push_data, pc_next, vec1, vec2;
    logic       stk_push, stk_pop, pc_load, busy, overflow, underflow;
    logic [9:0] stk_din, pc_vec;
    logic [1:0] in_service;

    int n_cmp  = 0;
    int n_fail = 0;

    intr_ctrl #(.PC_WIDTH(10), .STACK_DEPTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .irq1          (irq1),
        .irq2          (irq2),
        .ien           (ien),
        .reti          (reti),
        .cpu_push      (cpu_push),
        .cpu_pop       (cpu_pop),
        .cpu_push_data (cpu_push_data),
        .pc_next       (pc_next),
        .vec1          (vec1),
        .vec2          (vec2),
        .stk_push      (stk_push),
        .stk_pop       (stk_pop),
        .stk_din       (stk_din),
        .pc_load       (pc_load),
        .pc_vec        (pc_vec),
        .in_service    (in_service),
        .busy          (busy),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reti();
        reti = 1'b1;
        tick();
        reti = 1'b0;
    endtask

    initial begin
        reset = 1'b1; irq1 = 1'b0; irq2 = 1'b0; ien = 1'b1; reti = 1'b0;
        cpu_push = 1'b0; cpu_pop = 1'b0;
        cpu_push_data = 10'h155; pc_next = 10'h023; vec1 = 10'h200; vec2 = 10'h300;
        tick();
        tick();
        chk("rst_push",   32'(stk_push), 0);
        chk("rst_busy",   32'(busy), 0);
        chk("rst_insvc",  32'(in_service), 0);
        chk("rst_pcvec",  32'(pc_vec), 0);
        chk("rst_din",    32'(stk_din), 0);
        chk("rst_ovf",    32'(overflow), 0);
        chk("rst_udf",    32'(underflow), 0);
        reset = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 0);

        // Single irq1 entry and exit
        irq1 = 1'b1; tick(); irq1 = 1'b0;
        chk("t1_wait_push", 32'(stk_push), 0);
        tick();
        chk("t1_push",  32'(stk_push), 1);
        chk("t1_din",   32'(stk_din), 32'h023);
        chk("t1_busy",  32'(busy), 1);
        tick();
        chk("t1_load",  32'(pc_load), 1);
        chk("t1_vec",   32'(pc_vec), 32'h200);
        chk("t1_nopush", 32'(stk_push), 0);
        tick();
        chk("t1_insvc", 32'(in_service), 32'h1);
        chk("t1_noload", 32'(pc_load), 0);
        chk("t1_svc_busy", 32'(busy), 0);
        do_reti();
        chk("t1_pop",   32'(stk_pop), 1);
        chk("t1_ret_busy", 32'(busy), 1);
        tick();
        chk("t1_done_insvc", 32'(in_service), 0);
        chk("t1_done_pop", 32'(stk_pop), 0);

        // reti outside SERVICE does nothing
        do_reti();
        chk("reti_ign_pop",  32'(stk_pop), 0);
        chk("reti_ign_busy", 32'(busy), 0);

        // Pop on empty stack
        cpu_pop = 1'b1; #1;
        chk("udf_strobe", 32'(stk_pop), 0);
        tick(); cpu_pop = 1'b0;
        chk("udf_flag", 32'(underflow), 1);

        // Simultaneous irq1/irq2: irq1 first, irq2 after reti
        irq1 = 1'b1; irq2 = 1'b1; tick(); irq1 = 1'b0; irq2 = 1'b0;
        tick();
        chk("t2_push1", 32'(stk_push), 1);
        tick();
        chk("t2_vec1",  32'(pc_vec), 32'h200);
        tick();
        chk("t2_svc1",  32'(in_service), 32'h1);
        do_reti();
        tick();
        chk("t2_idle_insvc", 32'(in_service), 0);
        tick();
        chk("t2_push2", 32'(stk_push), 1);
        tick();
        chk("t2_vec2",  32'(pc_vec), 32'h300);
        tick();
        chk("t2_svc2",  32'(in_service), 32'h2);
        do_reti();
        tick();

        // ien low holds irq2 pending
        ien = 1'b0; irq2 = 1'b1; tick(); irq2 = 1'b0;
        tick(); tick();
        chk("t3_hold_busy", 32'(busy), 0);
        chk("t3_hold_push", 32'(stk_push), 0);
        ien = 1'b1;
        tick();
        chk("t3_push", 32'(stk_push), 1);
        tick();
        chk("t3_vec",  32'(pc_vec), 32'h300);
        tick();
        chk("t3_svc",  32'(in_service), 32'h2);
        do_reti();
        tick();

        // Fill the stack; entry must wait for room
        for (int i = 0; i < 8; i++) begin
            cpu_push = 1'b1; #1;
            chk("t4_fill_push", 32'(stk_push), 1);
            tick();
        end
        cpu_push = 1'b0;
        irq1 = 1'b1; tick(); irq1 = 1'b0;
        tick(); tick();
        chk("t4_blocked_busy", 32'(busy), 0);
        chk("t4_blocked_push", 32'(stk_push), 0);
        cpu_push = 1'b1; #1;
        chk("t4_ovf_strobe", 32'(stk_push), 0);
        tick(); cpu_push = 1'b0;
        chk("t4_ovf_flag", 32'(overflow), 1);
        cpu_pop = 1'b1; #1;
        chk("t4_pop", 32'(stk_pop), 1);
        tick(); cpu_pop = 1'b0;
        chk("t4_pop_busy", 32'(busy), 0);
        tick();
        chk("t4_entry_push", 32'(stk_push), 1);
        chk("t4_entry_din",  32'(stk_din), 32'h023);
        tick();
        chk("t4_entry_vec",  32'(pc_vec), 32'h200);
        tick();
        chk("t4_entry_svc",  32'(in_service), 32'h1);
        do_reti();
        tick();

        // Push+pop together cancel; then drain the remaining 7 entries
        cpu_push = 1'b1; cpu_pop = 1'b1; #1;
        chk("both_push", 32'(stk_push), 0);
        chk("both_pop",  32'(stk_pop), 0);
        tick(); cpu_push = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #1;
            chk("drain_pop", 32'(stk_pop), 1);
            tick();
        end
        #1;
        chk("drain_empty", 32'(stk_pop), 0);
        tick(); cpu_pop = 1'b0;

        // irq1 edge coincides with a program push
        cpu_push = 1'b1; irq1 = 1'b1; #1;
        chk("t5_pass_push", 32'(stk_push), 1);
        chk("t5_pass_din",  32'(stk_din), 32'h155);
        tick(); cpu_push = 1'b0; irq1 = 1'b0;
        tick();
        chk("t5_push", 32'(stk_push), 1);
        chk("t5_din",  32'(stk_din), 32'h023);
        tick();
        chk("t5_vec",  32'(pc_vec), 32'h200);
        tick();
        chk("t5_svc",  32'(in_service), 32'h1);
        do_reti();
        tick();
        cpu_pop = 1'b1; #1;
        chk("t5_pop_last", 32'(stk_pop), 1);
        tick(); #1;
        chk("t5_pop_empty", 32'(stk_pop), 0);
        tick(); cpu_pop = 1'b0;

        // Reset in JUMP
        irq1 = 1'b1; tick(); irq1 = 1'b0;
        tick(); tick();
        chk("t6_load", 32'(pc_load), 1);
        reset = 1'b1; #1;
        chk("t6_gate_load", 32'(pc_load), 0);
        tick(); reset = 1'b0;
        chk("t6_insvc", 32'(in_service), 0);
        chk("t6_busy",  32'(busy), 0);
        chk("t6_load_off", 32'(pc_load), 0);
        chk("t6_ovf_clr", 32'(overflow), 0);
        chk("t6_udf_clr", 32'(underflow), 0);
        tick(); tick();
        chk("t6_no_entry_push", 32'(stk_push), 0);
        chk("t6_no_entry_busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
